packet_serializer: RTL and testbench

//  Consumer end of the scheduler/selector -> serializer interface. When the scheduler raises activate,

---
 rtl/packet_serializer_if.sv | 44 ++++
 rtl/packet_serializer.sv | 136 +++++++++++++
 tb/tb_packet_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_serializer_if.sv
// ----------------------------------------------------------------------------
// packet_serializer_if
// Purpose : Master-side bus of the packet serializer. It carries an address
//           phase (fields plus a valid/ready pair) and a write-data channel
//           (beat data, strobes and last, plus a valid/ready pair).
// Modports:
//   master - the serializer. It drives the address fields, m_addr_valid,
//            m_wdata, m_wstrb, m_wlast and m_wvalid. It samples m_addr_ready
//            and m_wready.
//   slave  - the downstream AXI-side logic, with every direction reversed.
// ----------------------------------------------------------------------------
interface packet_serializer_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [7:0]              m_len;
    logic [2:0]              m_size;
    logic [1:0]              m_burst;
    logic [ID_WIDTH-1:0]     m_id;
    logic [USER_WIDTH-1:0]   m_user;
    logic                    m_is_write;
    logic                    m_addr_valid;
    logic                    m_addr_ready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wstrb;
    logic                    m_wlast;
    logic                    m_wvalid;
    logic                    m_wready;

    modport master (
        output m_addr, m_len, m_size, m_burst, m_id, m_user, m_is_write, m_addr_valid,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_addr_ready, m_wready
    );

    modport slave (
        input  m_addr, m_len, m_size, m_burst, m_id, m_user, m_is_write, m_addr_valid,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_addr_ready, m_wready
    );
endinterface

// File: rtl/packet_serializer.sv
// ----------------------------------------------------------------------------
// packet_serializer
// Purpose : Consumer end of the scheduler/selector -> serializer path. When
//           the scheduler raises activate, the block captures the whole
//           packet. It replays the packet as an address phase followed, for
//           writes, by the write-data beats. It then pulses consumed so the
//           scheduler pops the owning queue.
// Ports   :
//   clock     - single rising-edge clock
//   reset     - asynchronous, active-low reset
//   packet_in - packet from the selector; it is valid while activate=1
//   activate  - scheduler request to transmit packet_in
//   consumed  - one-cycle pulse when the packet has been fully transmitted
//   busy      - high whenever the FSM is not idle
//   len_error - one-cycle pulse when the captured len exceeds MAX_BEATS-1
//   bus       - master modport: address phase and write-data channel
// ----------------------------------------------------------------------------
module packet_serializer #(
    parameter int ADDR_WIDTH  = 40,
    parameter int ID_WIDTH    = 16,
    parameter int USER_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int MAX_BEATS   = 4,
    parameter int HEADER_SIZE = 102,
    parameter int DATA_SIZE   = HEADER_SIZE + MAX_BEATS*(DATA_WIDTH/8) + MAX_BEATS*DATA_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] packet_in,
    input  logic                 activate,
    output logic                 consumed,
    output logic                 busy,
    output logic                 len_error,
    packet_serializer_if.master  bus
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int LEN_LSB   = ADDR_WIDTH;
    localparam int SIZE_LSB  = LEN_LSB + 8;
    localparam int BURST_LSB = SIZE_LSB + 3;
    localparam int ID_LSB    = BURST_LSB + 2;
    localparam int WR_BIT    = ID_LSB + ID_WIDTH;
    localparam int USER_LSB  = WR_BIT + 1;
    localparam int STRB_LSB  = HEADER_SIZE;
    localparam int DATA_LSB  = HEADER_SIZE + MAX_BEATS*STRB_W;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [DATA_SIZE-1:0] pkt;
    logic [BEAT_W-1:0]    beat;
    logic                 guard;
    logic [7:0]           cap_len;
    logic [7:0]           eff_len;
    logic                 last_beat;

    logic [DATA_WIDTH-1:0] beat_data [MAX_BEATS];
    logic [STRB_W-1:0]     beat_strb [MAX_BEATS];

    for (genvar k = 0; k < MAX_BEATS; k++) begin : g_beats
        assign beat_data[k] = pkt[DATA_LSB + k*DATA_WIDTH +: DATA_WIDTH];
        assign beat_strb[k] = pkt[STRB_LSB + k*STRB_W +: STRB_W];
    end

    // An oversized len is clamped so the beat counter never leaves the stored beats.
    assign cap_len   = pkt[LEN_LSB +: 8];
    assign eff_len   = (cap_len > MAX_LEN) ? MAX_LEN : cap_len;
    assign last_beat = (8'(beat) == eff_len);

    // guard is high for the first idle cycle after DONE. The scheduler is
    // still popping its queue in that cycle, so the stale activate must not
    // start a second transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pkt       <= '0;
            beat      <= '0;
            guard     <= 1'b0;
            len_error <= 1'b0;
        end else begin
            len_error <= 1'b0;
            guard     <= 1'b0;
            case (state)
                IDLE: begin
                    if (activate && !guard) begin
                        pkt       <= packet_in;
                        len_error <= (packet_in[LEN_LSB +: 8] > MAX_LEN);
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_addr_ready) begin
                        state <= pkt[WR_BIT] ? DATA : DONE;
                    end
                end
                DATA: begin
                    if (bus.m_wready) begin
                        if (last_beat) begin
                            beat  <= '0;
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    guard <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode from registers only, so ready never reaches valid combinationally.
    assign busy     = (state != IDLE);
    assign consumed = (state == DONE);

    assign bus.m_addr_valid = (state == ADDR);
    assign bus.m_addr       = pkt[ADDR_WIDTH-1:0];
    assign bus.m_len        = eff_len;
    assign bus.m_size       = pkt[SIZE_LSB +: 3];
    assign bus.m_burst      = pkt[BURST_LSB +: 2];
    assign bus.m_id         = pkt[ID_LSB +: ID_WIDTH];
    assign bus.m_is_write   = pkt[WR_BIT];
    assign bus.m_user       = pkt[USER_LSB +: USER_WIDTH];

    assign bus.m_wvalid = (state == DATA);
    assign bus.m_wlast  = (state == DATA) && last_beat;
    assign bus.m_wdata  = (state == DATA) ? beat_data[beat] : '0;
    assign bus.m_wstrb  = (state == DATA) ? beat_strb[beat] : '0;
endmodule

// File: tb/tb_packet_serializer.sv
// ----------------------------------------------------------------------------
// tb_packet_serializer
// Purpose : Self-checking bench for packet_serializer. Each packet is
//           described as plain fields plus a list of beats. The expected bus
//           activity is derived from those fields: the address phase, then
//           min(len,3)+1 beats in order with wlast on the final beat, then
//           one consumed pulse followed by an ignored guard cycle.
// ----------------------------------------------------------------------------
module tb_packet_serializer;
    localparam int ADDR_WIDTH  = 40;
    localparam int ID_WIDTH    = 16;
    localparam int USER_WIDTH  = 32;
    localparam int DATA_WIDTH  = 128;
    localparam int MAX_BEATS   = 4;
    localparam int HEADER_SIZE = 102;
    localparam int DATA_SIZE   = HEADER_SIZE + MAX_BEATS*16 + MAX_BEATS*128;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [DATA_SIZE-1:0] packet_in;
    logic                 activate;
    logic                 consumed;
    logic                 busy;
    logic                 len_error;

    packet_serializer_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH),
        .USER_WIDTH(USER_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    packet_serializer #(
        .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .USER_WIDTH(USER_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MAX_BEATS(MAX_BEATS), .HEADER_SIZE(HEADER_SIZE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .packet_in (packet_in),
        .activate  (activate),
        .consumed  (consumed),
        .busy      (busy),
        .len_error (len_error),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Fields of the packet currently being sent.
    logic [39:0]  e_addr;
    logic [7:0]   e_len;
    logic [2:0]   e_size;
    logic [1:0]   e_burst;
    logic [15:0]  e_id;
    logic         e_wr;
    logic [31:0]  e_user;
    logic [15:0]  e_strb [4];
    logic [127:0] e_data [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic timeout_fail(input string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic new_packet(input logic wr, input logic [7:0] len);
        e_addr  = {8'($urandom), $urandom};
        e_len   = len;
        e_size  = 3'($urandom);
        e_burst = 2'($urandom);
        e_id    = 16'($urandom);
        e_wr    = wr;
        e_user  = $urandom;
        for (int k = 0; k < 4; k++) begin
            e_strb[k] = 16'($urandom);
            e_data[k] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    function automatic logic [DATA_SIZE-1:0] encode_packet();
        logic [DATA_SIZE-1:0] p;
        p          = '0;
        p[39:0]    = e_addr;
        p[47:40]   = e_len;
        p[50:48]   = e_size;
        p[52:51]   = e_burst;
        p[68:53]   = e_id;
        p[69]      = e_wr;
        p[101:70]  = e_user;
        for (int k = 0; k < 4; k++) begin
            p[102 + k*16 +: 16]   = e_strb[k];
            p[166 + k*128 +: 128] = e_data[k];
        end
        return p;
    endfunction

    function automatic logic [DATA_SIZE-1:0] junk_packet();
        logic [DATA_SIZE-1:0] p;
        for (int i = 0; i < DATA_SIZE; i++) p[i] = 1'($urandom);
        return p;
    endfunction

    // Address ready modes: 0 = always high, 1 = random, 2 = low for 10 cycles.
    // Write ready modes:   0 = always high, 1 = toggling 1/0, 2 = random.
    // The hold flag keeps activate high after capture.
    task automatic apply_stimulus(input int addr_mode, input int w_mode, input bit hold);
        logic [7:0] eff;
        int         k;
        int         cyc;
        bit         hs;
        logic       rdy;
        eff = (e_len > 8'd3) ? 8'd3 : e_len;
        packet_in = encode_packet();
        activate  = 1'b1;
        tick();
        activate  = hold;
        packet_in = junk_packet();
        check_output("len_error_pulse", len_error, e_len > 8'd3);

        cyc = 0;
        hs  = 1'b0;
        while (!hs && cyc < 64) begin
            rdy = (addr_mode == 0) ? 1'b1 : (addr_mode == 1) ? 1'($urandom) : (cyc >= 10);
            bus.m_addr_ready = rdy;
            check_output("addr_valid", bus.m_addr_valid, 1'b1);
            check_output("addr",       bus.m_addr, e_addr);
            check_output("len",        bus.m_len, eff);
            check_output("size",       bus.m_size, e_size);
            check_output("burst",      bus.m_burst, e_burst);
            check_output("id",         bus.m_id, e_id);
            check_output("user",       bus.m_user, e_user);
            check_output("is_write",   bus.m_is_write, e_wr);
            check_output("wvalid_in_addr", bus.m_wvalid, 1'b0);
            check_output("consumed_in_addr", consumed, 1'b0);
            tick();
            cyc++;
            hs = rdy;
        end
        bus.m_addr_ready = 1'b0;
        if (!hs) begin
            timeout_fail("addr_handshake");
            return;
        end

        if (e_wr) begin
            k   = 0;
            cyc = 0;
            while (k <= int'(eff) && cyc < 64) begin
                rdy = (w_mode == 0) ? 1'b1 : (w_mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
                bus.m_wready = rdy;
                check_output("wvalid",  bus.m_wvalid, 1'b1);
                check_output("wdata",   bus.m_wdata, e_data[k]);
                check_output("wstrb",   bus.m_wstrb, e_strb[k]);
                check_output("wlast",   bus.m_wlast, k == int'(eff));
                check_output("addr_valid_in_data", bus.m_addr_valid, 1'b0);
                check_output("consumed_in_data", consumed, 1'b0);
                tick();
                cyc++;
                if (rdy) k++;
            end
            bus.m_wready = 1'b0;
            if (k <= int'(eff)) begin
                timeout_fail("data_handshake");
                return;
            end
        end

        check_output("consumed_pulse", consumed, 1'b1);
        check_output("wvalid_after_last", bus.m_wvalid, 1'b0);
        check_output("busy_done", busy, 1'b1);
        check_output("len_error_clear", len_error, 1'b0);
        tick();
        check_output("consumed_once", consumed, 1'b0);
        check_output("busy_guard", busy, 1'b0);
        tick();
        check_output("guard_no_restart", busy, 1'b0);
        check_output("guard_no_addr", bus.m_addr_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        activate         = 1'b0;
        packet_in        = '0;
        bus.m_addr_ready = 1'b0;
        bus.m_wready     = 1'b0;
        #1;
        check_output("rst_addr_valid", bus.m_addr_valid, 1'b0);
        check_output("rst_wvalid",     bus.m_wvalid, 1'b0);
        check_output("rst_consumed",   consumed, 1'b0);
        check_output("rst_busy",       busy, 1'b0);
        check_output("rst_len_error",  len_error, 1'b0);
        check_output("rst_addr",       bus.m_addr, 40'h0);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        tick();

        $display("[TB] read with fixed address");
        new_packet(1'b0, 8'd0);
        e_addr = 40'h12_3456_7800;
        apply_stimulus(0, 0, 1'b0);

        $display("[TB] write len=3, wready toggling");
        new_packet(1'b1, 8'd3);
        apply_stimulus(0, 1, 1'b0);

        $display("[TB] address ready held low for 10 cycles");
        new_packet(1'b1, 8'd1);
        apply_stimulus(2, 0, 1'b0);

        $display("[TB] oversized len=7 write");
        new_packet(1'b1, 8'd7);
        apply_stimulus(0, 2, 1'b0);

        $display("[TB] activate held across two packets");
        new_packet(1'b1, 8'd0);
        apply_stimulus(0, 0, 1'b1);
        new_packet(1'b0, 8'd2);
        apply_stimulus(0, 0, 1'b0);

        $display("[TB] randomized packets");
        for (int n = 0; n < 12; n++) begin
            new_packet(1'($urandom), 8'($urandom_range(5, 0)));
            apply_stimulus(1, 2, 1'($urandom));
        end

        $display("[TB] reset during data beat 1");
        new_packet(1'b1, 8'd3);
        packet_in = encode_packet();
        activate  = 1'b1;
        tick();
        activate         = 1'b0;
        bus.m_addr_ready = 1'b1;
        tick();
        bus.m_addr_ready = 1'b0;
        bus.m_wready     = 1'b1;
        check_output("rst_test_beat0", bus.m_wdata, e_data[0]);
        tick();
        bus.m_wready = 1'b0;
        check_output("rst_test_beat1", bus.m_wdata, e_data[1]);
        #2 reset = 1'b0;
        #1;
        check_output("async_addr_valid", bus.m_addr_valid, 1'b0);
        check_output("async_wvalid",     bus.m_wvalid, 1'b0);
        check_output("async_wlast",      bus.m_wlast, 1'b0);
        check_output("async_wdata",      bus.m_wdata, 128'h0);
        check_output("async_wstrb",      bus.m_wstrb, 16'h0);
        check_output("async_addr",       bus.m_addr, 40'h0);
        check_output("async_busy",       busy, 1'b0);
        check_output("async_consumed",   consumed, 1'b0);
        @(posedge clock);
        #3 reset = 1'b1;
        bus.m_wready     = 1'b1;
        bus.m_addr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_output("post_rst_busy",     busy, 1'b0);
            check_output("post_rst_consumed", consumed, 1'b0);
            check_output("post_rst_wvalid",   bus.m_wvalid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
